// File: rtl/obj_dma_sequencer.sv
// Object-table DMA sequencer: latches a CPU DMA request, waits for the next
// vblank rising edge, programs the copy engine with three register writes,
// then tracks the engine's busy handshake with a watchdog. Completion raises a
// sticky interrupt; watchdog expiry additionally raises a sticky error flag.
module obj_dma_sequencer #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int START_WINDOW   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        cpu_req,
   input  logic [7:0]  cpu_obj_ptr,
   input  logic [2:0]  cpu_pal_bank,
   input  logic        cpu_buf_cs,
   input  logic        vblank,
   input  logic        ga_busy,
   output logic        ga_reg_cs,
   output logic        ga_wr,
   output logic [10:0] ga_addr,
   output logic [15:0] ga_din,
   output logic        cpu_wait,
   output logic        dma_irq,
   input  logic        irq_ack,
   output logic        dma_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] SW_LAST  = CW'(START_WINDOW - 1);
   localparam logic [CW-1:0] CNT_SAT  = '1;

   typedef enum logic [2:0] {
      IDLE, ARMED, WR_PTR, WR_MODE, WR_GO, WAIT_START, WAIT_DONE, DONE
   } state_t;

   typedef struct packed {
      logic [7:0] ptr;
      logic [2:0] bank;
   } dma_req_t;

   state_t         state;
   dma_req_t       act_req;
   dma_req_t       pend_req;
   dma_req_t       cpu_in;
   logic           pend;
   logic           vblank_prev;
   logic [CW-1:0]  wdog;

   assign cpu_in = '{ptr: cpu_obj_ptr, bank: cpu_pal_bank};

   // CPU is stalled while the copy engine owns the buffer
   assign cpu_wait = cpu_buf_cs &&
                     (state == WR_PTR || state == WR_MODE || state == WR_GO ||
                      state == WAIT_START || state == WAIT_DONE);

   // Sequencer FSM with registered bus outputs, watchdog, irq/err flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         act_req     <= '0;
         pend_req    <= '0;
         pend        <= 1'b0;
         vblank_prev <= 1'b0;
         wdog        <= '0;
         ga_reg_cs   <= 1'b0;
         ga_wr       <= 1'b0;
         ga_addr     <= '0;
         ga_din      <= '0;
         dma_irq     <= 1'b0;
         dma_err     <= 1'b0;
      end else if (ce) begin
         vblank_prev <= vblank;

         // the DONE cycle is the set event; it beats a coincident ack
         if (state == DONE)
            dma_irq <= 1'b1;
         else if (irq_ack)
            dma_irq <= 1'b0;

         // requests arriving mid-sequence queue one deep, newest wins
         if (cpu_req && state != IDLE) begin
            pend     <= 1'b1;
            pend_req <= cpu_in;
         end

         case (state)
            IDLE: begin
               if (cpu_req) begin
                  act_req <= cpu_in;
                  state   <= ARMED;
               end
            end
            ARMED: begin
               // edge only: a vblank already high when armed must not start
               if (vblank && !vblank_prev) begin
                  state     <= WR_PTR;
                  ga_reg_cs <= 1'b1;
                  ga_wr     <= 1'b1;
                  ga_addr   <= 11'h000;
                  ga_din    <= {8'h00, act_req.ptr};
               end
            end
            WR_PTR: begin
               state   <= WR_MODE;
               ga_addr <= 11'h002;
               ga_din  <= {5'b0, act_req.bank, 8'h00};
            end
            WR_MODE: begin
               state   <= WR_GO;
               ga_addr <= 11'h004;
               ga_din  <= 16'h0000;
            end
            WR_GO: begin
               state     <= WAIT_START;
               ga_reg_cs <= 1'b0;
               ga_wr     <= 1'b0;
               ga_addr   <= '0;
               ga_din    <= '0;
               wdog      <= '0;
            end
            WAIT_START: begin
               if (ga_busy) begin
                  state <= WAIT_DONE;
                  wdog  <= '0;
               end else if (wdog >= SW_LAST) begin
                  dma_err <= 1'b1;
                  state   <= DONE;
               end else if (wdog != CNT_SAT) begin
                  wdog <= wdog + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!ga_busy) begin
                  state <= DONE;
               end else if (wdog >= TO_LAST) begin
                  dma_err <= 1'b1;
                  state   <= DONE;
               end else if (wdog != CNT_SAT) begin
                  wdog <= wdog + 1'b1;
               end
            end
            DONE: begin
               // a request in this very cycle is newer than any pending one
               if (pend || cpu_req) begin
                  act_req <= cpu_req ? cpu_in : pend_req;
                  pend    <= 1'b0;
                  state   <= ARMED;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_obj_dma_sequencer.sv
// Directed bench for obj_dma_sequencer: register-write sequence, vblank edge
// qualification, pending re-arm, watchdogs, irq/ack, reset abort, ce hold.
module tb_obj_dma_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic        cpu_req;
   logic [7:0]  cpu_obj_ptr;
   logic [2:0]  cpu_pal_bank;
   logic        cpu_buf_cs;
   logic        vblank;
   logic        ga_busy;
   logic        ga_reg_cs;
   logic        ga_wr;
   logic [10:0] ga_addr;
   logic [15:0] ga_din;
   logic        cpu_wait;
   logic        dma_irq;
   logic        irq_ack;
   logic        dma_err;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int go_count = 0;

   logic [28:0] bus;
   assign bus = {ga_reg_cs, ga_wr, ga_addr, ga_din};

   obj_dma_sequencer dut (
      .clk(clk), .reset(reset), .ce(ce), .cpu_req(cpu_req),
      .cpu_obj_ptr(cpu_obj_ptr), .cpu_pal_bank(cpu_pal_bank),
      .cpu_buf_cs(cpu_buf_cs), .vblank(vblank), .ga_busy(ga_busy),
      .ga_reg_cs(ga_reg_cs), .ga_wr(ga_wr), .ga_addr(ga_addr),
      .ga_din(ga_din), .cpu_wait(cpu_wait), .dma_irq(dma_irq),
      .irq_ack(irq_ack), .dma_err(dma_err)
   );

   always #5 clk = ~clk;

   // count register writes that the copy engine would accept
   always @(negedge clk) begin
      if (!reset && ce && ga_reg_cs && ga_wr) begin
         wr_count++;
         if (ga_addr == 11'h004) go_count++;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      reset = 1'b1; ce = 1'b1; cpu_req = 1'b0; cpu_obj_ptr = '0;
      cpu_pal_bank = '0; cpu_buf_cs = 1'b0; vblank = 1'b0; ga_busy = 1'b0;
      irq_ack = 1'b0;
      tick; tick;
      reset = 1'b0;
      tick;
   endtask

   // from IDLE with vblank low: request, then vblank edge; ends in WR_PTR
   task automatic start_seq(input logic [7:0] p, input logic [2:0] b);
      cpu_obj_ptr = p; cpu_pal_bank = b; cpu_req = 1'b1;
      tick;
      cpu_req = 1'b0; vblank = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      apply_reset;
      cpu_buf_cs = 1'b1;
      #1;
      checks++;
      if (bus !== 29'h0) begin
         errors++; $display("FAIL reset_bus got %h want %h", bus, 29'h0);
      end
      checks++;
      if ({dma_irq, dma_err, cpu_wait} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b want 000", {dma_irq, dma_err, cpu_wait});
      end
      cpu_buf_cs = 1'b0;
   endtask

   task automatic test_basic;
      int w0;
      apply_reset;
      w0 = wr_count;
      start_seq(8'h20, 3'd3);
      checks++;
      if (bus !== {1'b1, 1'b1, 11'h000, 16'h0020}) begin
         errors++; $display("FAIL basic_wr_ptr got %h want %h", bus, {1'b1, 1'b1, 11'h000, 16'h0020});
      end
      tick;
      checks++;
      if (bus !== {1'b1, 1'b1, 11'h002, 16'h0300}) begin
         errors++; $display("FAIL basic_wr_mode got %h want %h", bus, {1'b1, 1'b1, 11'h002, 16'h0300});
      end
      tick;
      checks++;
      if (bus !== {1'b1, 1'b1, 11'h004, 16'h0000}) begin
         errors++; $display("FAIL basic_wr_go got %h want %h", bus, {1'b1, 1'b1, 11'h004, 16'h0000});
      end
      tick;
      cpu_buf_cs = 1'b1;
      #1;
      checks++;
      if ({bus, cpu_wait} !== {29'h0, 1'b1}) begin
         errors++; $display("FAIL basic_wait_start got %h want %h", {bus, cpu_wait}, {29'h0, 1'b1});
      end
      ga_busy = 1'b1;
      for (int i = 0; i < 10; i++) tick;
      ga_busy = 1'b0;
      tick; tick;
      checks++;
      if ({dma_irq, dma_err, cpu_wait} !== 3'b100) begin
         errors++; $display("FAIL basic_done got %b want 100", {dma_irq, dma_err, cpu_wait});
      end
      checks++;
      if (wr_count - w0 !== 3) begin
         errors++; $display("FAIL basic_write_count got %0d want 3", wr_count - w0);
      end
      irq_ack = 1'b1;
      tick;
      irq_ack = 1'b0;
      checks++;
      if (dma_irq !== 1'b0) begin
         errors++; $display("FAIL basic_ack got %b want 0", dma_irq);
      end
      cpu_buf_cs = 1'b0;
   endtask

   task automatic test_level_vblank;
      int w0;
      apply_reset;
      vblank = 1'b1;
      tick; tick;
      cpu_obj_ptr = 8'h33; cpu_pal_bank = 3'd2; cpu_req = 1'b1;
      tick;
      cpu_req = 1'b0;
      w0 = wr_count;
      for (int i = 0; i < 5; i++) tick;
      checks++;
      if ({wr_count - w0, ga_reg_cs} !== {32'd0, 1'b0}) begin
         errors++; $display("FAIL level_no_start got %0d writes cs %b want 0", wr_count - w0, ga_reg_cs);
      end
      vblank = 1'b0;
      tick; tick;
      checks++;
      if (ga_reg_cs !== 1'b0) begin
         errors++; $display("FAIL level_fall got %b want 0", ga_reg_cs);
      end
      vblank = 1'b1;
      tick;
      checks++;
      if (bus !== {1'b1, 1'b1, 11'h000, 16'h0033}) begin
         errors++; $display("FAIL level_rise got %h want %h", bus, {1'b1, 1'b1, 11'h000, 16'h0033});
      end
   endtask

   task automatic test_pending;
      apply_reset;
      start_seq(8'h20, 3'd3);
      tick; tick;
      ga_busy = 1'b1;
      tick; tick;
      cpu_obj_ptr = 8'h40; cpu_pal_bank = 3'd5; cpu_req = 1'b1; vblank = 1'b0;
      tick;
      cpu_req = 1'b0; cpu_buf_cs = 1'b1;
      #1;
      checks++;
      if (cpu_wait !== 1'b1) begin
         errors++; $display("FAIL pend_wait_done got %b want 1", cpu_wait);
      end
      tick; tick;
      ga_busy = 1'b0;
      tick; tick;
      checks++;
      if ({dma_irq, cpu_wait, ga_reg_cs} !== 3'b100) begin
         errors++; $display("FAIL pend_armed got %b want 100", {dma_irq, cpu_wait, ga_reg_cs});
      end
      cpu_buf_cs = 1'b0;
      vblank = 1'b1;
      tick;
      checks++;
      if (bus !== {1'b1, 1'b1, 11'h000, 16'h0040}) begin
         errors++; $display("FAIL pend_wr_ptr got %h want %h", bus, {1'b1, 1'b1, 11'h000, 16'h0040});
      end
      tick;
      checks++;
      if (bus !== {1'b1, 1'b1, 11'h002, 16'h0500}) begin
         errors++; $display("FAIL pend_wr_mode got %h want %h", bus, {1'b1, 1'b1, 11'h002, 16'h0500});
      end
   endtask

   task automatic test_start_timeout;
      apply_reset;
      start_seq(8'h11, 3'd1);
      tick; tick; tick;
      tick; tick; tick;
      checks++;
      if (dma_err !== 1'b0) begin
         errors++; $display("FAIL start_early got %b want 0", dma_err);
      end
      tick;
      checks++;
      if (dma_err !== 1'b1) begin
         errors++; $display("FAIL start_timeout got %b want 1", dma_err);
      end
      tick;
      checks++;
      if (dma_irq !== 1'b1) begin
         errors++; $display("FAIL start_irq got %b want 1", dma_irq);
      end
      irq_ack = 1'b1;
      tick;
      irq_ack = 1'b0;
      tick;
      checks++;
      if ({dma_irq, dma_err} !== 2'b01) begin
         errors++; $display("FAIL err_sticky got %b want 01", {dma_irq, dma_err});
      end
   endtask

   task automatic test_busy_stuck;
      apply_reset;
      start_seq(8'h22, 3'd2);
      ga_busy = 1'b1;
      tick; tick; tick;
      tick;
      for (int i = 0; i < 4095; i++) tick;
      checks++;
      if (dma_err !== 1'b0) begin
         errors++; $display("FAIL stuck_early got %b want 0", dma_err);
      end
      tick;
      checks++;
      if (dma_err !== 1'b1) begin
         errors++; $display("FAIL stuck_timeout got %b want 1", dma_err);
      end
      tick;
      checks++;
      if (dma_irq !== 1'b1) begin
         errors++; $display("FAIL stuck_irq got %b want 1", dma_irq);
      end
      ga_busy = 1'b0;
   endtask

   task automatic test_ack_coincident;
      apply_reset;
      start_seq(8'h05, 3'd0);
      tick; tick;
      ga_busy = 1'b1;
      tick; tick;
      ga_busy = 1'b0;
      tick;
      irq_ack = 1'b1;
      tick;
      irq_ack = 1'b0;
      checks++;
      if (dma_irq !== 1'b1) begin
         errors++; $display("FAIL ack_coincident got %b want 1", dma_irq);
      end
      irq_ack = 1'b1;
      tick;
      irq_ack = 1'b0;
      checks++;
      if (dma_irq !== 1'b0) begin
         errors++; $display("FAIL ack_later got %b want 0", dma_irq);
      end
   endtask

   task automatic test_reset_mid;
      int g0;
      apply_reset;
      start_seq(8'h7e, 3'd6);
      tick;
      checks++;
      if (bus !== {1'b1, 1'b1, 11'h002, 16'h0600}) begin
         errors++; $display("FAIL rmid_wr_mode got %h want %h", bus, {1'b1, 1'b1, 11'h002, 16'h0600});
      end
      g0 = go_count;
      cpu_buf_cs = 1'b1;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus, dma_irq, dma_err, cpu_wait} !== 32'h0) begin
         errors++; $display("FAIL rmid_async got %h want 0", {bus, dma_irq, dma_err, cpu_wait});
      end
      tick; tick;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) tick;
      checks++;
      if ({go_count - g0, ga_reg_cs} !== {32'd0, 1'b0}) begin
         errors++; $display("FAIL rmid_no_go got %0d go writes cs %b want 0", go_count - g0, ga_reg_cs);
      end
      cpu_buf_cs = 1'b0;
   endtask

   task automatic test_ce_hold;
      int w0;
      apply_reset;
      w0 = wr_count;
      ce = 1'b0;
      cpu_obj_ptr = 8'h55; cpu_req = 1'b1;
      tick; tick; tick;
      cpu_req = 1'b0; ce = 1'b1; vblank = 1'b1;
      tick; tick; tick;
      checks++;
      if ({wr_count - w0, ga_reg_cs} !== {32'd0, 1'b0}) begin
         errors++; $display("FAIL ce_req_ignored got %0d writes cs %b want 0", wr_count - w0, ga_reg_cs);
      end
      vblank = 1'b0;
      tick;
      start_seq(8'h66, 3'd4);
      ce = 1'b0;
      tick; tick; tick;
      checks++;
      if (bus !== {1'b1, 1'b1, 11'h000, 16'h0066}) begin
         errors++; $display("FAIL ce_hold got %h want %h", bus, {1'b1, 1'b1, 11'h000, 16'h0066});
      end
      ce = 1'b1;
      tick;
      checks++;
      if (bus !== {1'b1, 1'b1, 11'h002, 16'h0400}) begin
         errors++; $display("FAIL ce_resume got %h want %h", bus, {1'b1, 1'b1, 11'h002, 16'h0400});
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_basic;
      test_level_vblank;
      test_pending;
      test_start_timeout;
      test_busy_stuck;
      test_ack_coincident;
      test_reset_mid;
      test_ce_hold;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
